// File: rtl/pedestrian_display_pkg.sv
package pedestrian_display_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    STORE
  } conv_state_t;

  // Clock cycles per countdown unit.
  function automatic int unsigned div_of(input int unsigned clk_freq,
                                         input int unsigned tick_hz);
    return clk_freq / tick_hz;
  endfunction

  // Clock cycles per half flash period.
  function automatic int unsigned flash_div_of(input int unsigned clk_freq,
                                               input int unsigned flash_hz);
    int unsigned d;
    d = clk_freq / (2 * flash_hz);
    return (d == 0) ? 1 : d;
  endfunction

  // Bits needed to count 0..count-1.
  function automatic int unsigned width_for(input int unsigned count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  // Largest value shown on a display of the given digit count.
  function automatic longint unsigned bcd_max(input int unsigned digits);
    longint unsigned m;
    m = 1;
    for (int unsigned i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/pedestrian_countdown_display_if.sv
interface pedestrian_countdown_display_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned BCD_DIGITS = 4
);
  logic [NUM_CH-1:0]              ch_enable;
  logic [NUM_CH-1:0]              ch_start;
  logic [NUM_CH*TIME_W-1:0]       ch_load;
  logic [NUM_CH*TIME_W-1:0]       time_left;
  logic [NUM_CH-1:0]              ch_active;
  logic [NUM_CH-1:0]              ch_flash;
  logic [NUM_CH-1:0]              ch_expired;
  logic [NUM_CH*4*BCD_DIGITS-1:0] bcd_out;
  logic [NUM_CH-1:0]              bcd_valid;

  modport master (
    output ch_enable, ch_start, ch_load,
    input  time_left, ch_active, ch_flash, ch_expired, bcd_out, bcd_valid
  );

  modport slave (
    input  ch_enable, ch_start, ch_load,
    output time_left, ch_active, ch_flash, ch_expired, bcd_out, bcd_valid
  );
endinterface

// File: rtl/bcd_double_dabble_seq.sv
module bcd_double_dabble_seq
  import pedestrian_display_pkg::*;
#(
  parameter int unsigned TIME_W     = 16,
  parameter int unsigned BCD_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TIME_W-1:0]       bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  localparam int unsigned     BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned     CNT_W = width_for(TIME_W);
  localparam longint unsigned MAX_V = bcd_max(BCD_DIGITS);

  conv_state_t       state, state_nxt;
  logic [TIME_W-1:0] bin_q;
  logic [BCD_W-1:0]  acc, acc_adj;
  logic [CNT_W-1:0]  cnt;
  logic              last_shift;

  assign last_shift = (cnt == CNT_W'(TIME_W - 1));
  assign bcd        = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      LOAD:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = STORE;
      STORE: begin
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // Snapshot saturates to the display maximum so the result always fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (start) begin
            bin_q <= (64'(bin) > MAX_V) ? TIME_W'(MAX_V) : bin;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          {acc, bin_q} <= {acc_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt          <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pedestrian_countdown_display.sv
module pedestrian_countdown_display
  import pedestrian_display_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TICK_HZ      = 10,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TIME_W       = 16,
  parameter int unsigned BCD_DIGITS   = 4,
  parameter int unsigned FLASH_THRESH = 50,
  parameter int unsigned FLASH_HZ     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  pedestrian_countdown_display_if.slave  bus
);
  localparam int unsigned DIV       = div_of(CLK_FREQ, TICK_HZ);
  localparam int unsigned FLASH_DIV = flash_div_of(CLK_FREQ, FLASH_HZ);
  localparam int unsigned PRESC_W   = width_for(DIV);
  localparam int unsigned FLASH_W   = width_for(FLASH_DIV);
  localparam int unsigned PTR_W     = width_for(NUM_CH);
  localparam int unsigned BCD_W     = 4 * BCD_DIGITS;

  logic [FLASH_W-1:0]      flash_cnt;
  logic                    flash_phase;
  logic [TIME_W-1:0]       tl [NUM_CH];
  logic [PTR_W-1:0]        ptr;
  logic [NUM_CH*BCD_W-1:0] bcd_q;
  logic [NUM_CH-1:0]       valid_q;
  logic                    conv_done;
  logic [BCD_W-1:0]        conv_bcd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
      flash_cnt   <= '0;
      flash_phase <= ~flash_phase;
    end else begin
      flash_cnt   <= flash_cnt + FLASH_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PRESC_W-1:0] presc;
    logic [TIME_W-1:0]  count;
    logic [TIME_W-1:0]  load;
    logic               active;
    logic               expired;
    logic               flash;

    assign load = bus.ch_load[k*TIME_W +: TIME_W];

    // Priority: disable, then start (wins over a coincident tick), then tick.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count   <= '0;
        presc   <= '0;
        active  <= 1'b0;
        expired <= 1'b0;
      end else begin
        expired <= 1'b0;
        if (!bus.ch_enable[k]) begin
          count  <= '0;
          presc  <= '0;
          active <= 1'b0;
        end else if (bus.ch_start[k]) begin
          count  <= load;
          presc  <= '0;
          active <= (load != '0);
        end else if (active) begin
          if (presc == PRESC_W'(DIV - 1)) begin
            presc <= '0;
            count <= count - TIME_W'(1);
            if (count == TIME_W'(1)) begin
              active  <= 1'b0;
              expired <= 1'b1;
            end
          end else begin
            presc <= presc + PRESC_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) flash <= 1'b0;
      else     flash <= active && (64'(count) <= 64'(FLASH_THRESH)) && flash_phase;
    end

    assign tl[k]                              = count;
    assign bus.time_left[k*TIME_W +: TIME_W] = count;
    assign bus.ch_active[k]                   = active;
    assign bus.ch_expired[k]                  = expired;
    assign bus.ch_flash[k]                    = flash;
  end

  bcd_double_dabble_seq #(
    .TIME_W     (TIME_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (1'b1),
    .bin   (tl[ptr]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Round-robin refresh: one channel per completed conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q   <= '0;
      valid_q <= '0;
      ptr     <= '0;
    end else if (conv_done) begin
      bcd_q[BCD_W*ptr +: BCD_W] <= conv_bcd;
      valid_q[ptr]              <= 1'b1;
      ptr <= (ptr == PTR_W'(NUM_CH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = valid_q;

endmodule

// File: tb/tb_pedestrian_countdown_display.sv
module tb_pedestrian_countdown_display;
  localparam int unsigned NCH  = 2;
  localparam int unsigned TW   = 16;
  localparam int unsigned BD   = 4;
  localparam int unsigned DIVV = 10;
  localparam int unsigned FDIV = 5;
  localparam int unsigned THR  = 2;
  localparam int unsigned CONV = TW + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pedestrian_countdown_display_if #(.NUM_CH(NCH), .TIME_W(TW), .BCD_DIGITS(BD)) bus ();

  pedestrian_countdown_display #(
    .CLK_FREQ     (100),
    .TICK_HZ      (10),
    .NUM_CH       (NCH),
    .TIME_W       (TW),
    .BCD_DIGITS   (BD),
    .FLASH_THRESH (THR),
    .FLASH_HZ     (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] tl_of(input int k);
    return 64'(bus.time_left[k*TW +: TW]);
  endfunction

  function automatic logic [63:0] bcd_of(input int k);
    return 64'(bus.bcd_out[k*4*BD +: 4*BD]);
  endfunction

  // Behavioural model: countdown as elapsed cycles since load, digits by division.
  int unsigned m_tl [NCH];
  int unsigned m_load [NCH];
  int unsigned m_el [NCH];
  bit          m_act [NCH];
  bit          m_exp [NCH];
  bit          m_fl [NCH];
  bit          m_val [NCH];
  int unsigned m_bcd [NCH];
  int unsigned snap, snap_ch, n;
  bit          cmp_on = 1'b0;

  function automatic int unsigned to_bcd(input int unsigned v);
    int unsigned s, r;
    s = (v > 9999) ? 9999 : v;
    r = 0;
    for (int i = 0; i < BD; i++) begin
      r = r | ((s % 10) << (4 * i));
      s = s / 10;
    end
    return r;
  endfunction

  function automatic bit phase_after(input int unsigned edges);
    return ((edges / FDIV) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0; snap = 0; snap_ch = 0;
      for (int k = 0; k < NCH; k++) begin
        m_tl[k] = 0; m_load[k] = 0; m_el[k] = 0; m_act[k] = 0;
        m_exp[k] = 0; m_fl[k] = 0; m_val[k] = 0; m_bcd[k] = 0;
      end
    end else begin
      n++;
      if ((n - 1) % CONV == 0) begin
        snap_ch = ((n - 1) / CONV) % NCH;
        snap    = m_tl[snap_ch];
      end
      for (int k = 0; k < NCH; k++) begin
        m_fl[k]  = m_act[k] && (m_tl[k] <= THR) && phase_after(n - 1);
        m_exp[k] = 1'b0;
        if (!bus.ch_enable[k]) begin
          m_tl[k]  = 0;
          m_act[k] = 1'b0;
        end else if (bus.ch_start[k]) begin
          m_load[k] = bus.ch_load[k*TW +: TW];
          m_el[k]   = 0;
          m_tl[k]   = m_load[k];
          m_act[k]  = (m_load[k] != 0);
        end else if (m_act[k]) begin
          m_el[k]++;
          m_tl[k] = m_load[k] - m_el[k] / DIVV;
          if (m_el[k] == m_load[k] * DIVV) begin
            m_act[k] = 1'b0;
            m_exp[k] = 1'b1;
          end
        end
      end
      if (n % CONV == 0) begin
        m_bcd[snap_ch] = to_bcd(snap);
        m_val[snap_ch] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      for (int k = 0; k < NCH; k++) begin
        chk($sformatf("time_left[%0d]", k), tl_of(k), 64'(m_tl[k]));
        chk($sformatf("ch_active[%0d]", k), 64'(bus.ch_active[k]), 64'(m_act[k]));
        chk($sformatf("ch_expired[%0d]", k), 64'(bus.ch_expired[k]), 64'(m_exp[k]));
        chk($sformatf("ch_flash[%0d]", k), 64'(bus.ch_flash[k]), 64'(m_fl[k]));
        chk($sformatf("bcd_out[%0d]", k), bcd_of(k), 64'(m_bcd[k]));
        chk($sformatf("bcd_valid[%0d]", k), 64'(bus.bcd_valid[k]), 64'(m_val[k]));
      end
    end
  end

  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic start_ch(input int k, input logic [TW-1:0] v);
    bus.ch_start[k]          = 1'b1;
    bus.ch_load[k*TW +: TW]  = v;
    @(negedge clk);
    bus.ch_start[k]          = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " time_left"}, 64'(bus.time_left), 64'd0);
    chk({tag, " ch_active"}, 64'(bus.ch_active), 64'd0);
    chk({tag, " ch_flash"}, 64'(bus.ch_flash), 64'd0);
    chk({tag, " ch_expired"}, 64'(bus.ch_expired), 64'd0);
    chk({tag, " bcd_out"}, 64'(bus.bcd_out), 64'd0);
    chk({tag, " bcd_valid"}, 64'(bus.bcd_valid), 64'd0);
  endtask

  initial begin
    int hi_cnt, lo_cnt;
    logic [TW-1:0] ld;
    int unsigned r;

    rst           = 1'b1;
    bus.ch_enable = '0;
    bus.ch_start  = '0;
    bus.ch_load   = '0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst    = 1'b0;
    cmp_on = 1'b1;
    bus.ch_enable = '1;
    cyc(1);

    // Load 3: decrements at +10/+20/+30, expiry pulse only at +30.
    start_ch(0, 16'd3);
    chk("load3 t0", tl_of(0), 64'd3);
    cyc(10); chk("load3 t10", tl_of(0), 64'd2);
    cyc(10); chk("load3 t20", tl_of(0), 64'd1);
    cyc(9);  chk("load3 exp t29", 64'(bus.ch_expired[0]), 64'd0);
    cyc(1);
    chk("load3 exp t30", 64'(bus.ch_expired[0]), 64'd1);
    chk("load3 tl t30", tl_of(0), 64'd0);
    chk("load3 act t30", 64'(bus.ch_active[0]), 64'd0);
    cyc(1);  chk("load3 exp t31", 64'(bus.ch_expired[0]), 64'd0);

    // Disable mid-count, then a start while disabled.
    start_ch(0, 16'd5);
    cyc(11);
    bus.ch_enable[0] = 1'b0;
    cyc(1);
    chk("dis tl", tl_of(0), 64'd0);
    chk("dis act", 64'(bus.ch_active[0]), 64'd0);
    chk("dis exp", 64'(bus.ch_expired[0]), 64'd0);
    start_ch(0, 16'd9);
    chk("dis start tl", tl_of(0), 64'd0);
    chk("dis start act", 64'(bus.ch_active[0]), 64'd0);
    bus.ch_enable[0] = 1'b1;
    cyc(2);

    // Restart on the tick cycle.
    start_ch(0, 16'd5);
    cyc(9);
    start_ch(0, 16'd7);
    chk("restart tl", tl_of(0), 64'd7);
    chk("restart exp", 64'(bus.ch_expired[0]), 64'd0);
    cyc(69);
    chk("restart exp t69", 64'(bus.ch_expired[0]), 64'd0);
    chk("restart tl t69", tl_of(0), 64'd1);
    cyc(1);
    chk("restart exp t70", 64'(bus.ch_expired[0]), 64'd1);
    chk("restart tl t70", tl_of(0), 64'd0);

    // BCD: holding start keeps the value steady across a full refresh.
    bus.ch_start[1] = 1'b1;
    bus.ch_load[TW +: TW] = 16'd1234;
    cyc(56);
    chk("bcd 1234", bcd_of(1), 64'h1234);
    chk("bcd valid1", 64'(bus.bcd_valid[1]), 64'd1);
    bus.ch_load[TW +: TW] = 16'd12345;
    cyc(56);
    chk("bcd sat", bcd_of(1), 64'h9999);
    bus.ch_start[1] = 1'b0;
    cyc(1);

    // Flash: off at 4,3; follows the phase at 2,1; off after expiry.
    start_ch(0, 16'd4);
    hi_cnt = 0;
    lo_cnt = 0;
    for (int i = 0; i <= 44; i++) begin
      if (i <= 20) chk($sformatf("flash off i=%0d", i), 64'(bus.ch_flash[0]), 64'd0);
      else if (i <= 40) begin
        if (bus.ch_flash[0]) hi_cnt++;
        else lo_cnt++;
      end else chk($sformatf("flash post i=%0d", i), 64'(bus.ch_flash[0]), 64'd0);
      cyc(1);
    end
    chk("flash seen high", 64'(hi_cnt > 0), 64'd1);
    chk("flash seen low", 64'(lo_cnt > 0), 64'd1);

    // Asynchronous reset mid-count.
    start_ch(0, 16'd3);
    cyc(5);
    #2 rst = 1'b1;
    #1 chk_all_zero("async rst");
    @(negedge clk);
    rst = 1'b0;
    cyc(20);
    chk("post rst tl", tl_of(0), 64'd0);
    chk("post rst act", 64'(bus.ch_active[0]), 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        bus.ch_start[k] = ($urandom_range(0, 999) < 15);
        if ($urandom_range(0, 99) < 1) bus.ch_enable[k] = ~bus.ch_enable[k];
        r = $urandom_range(0, 9);
        if (r < 7)      ld = TW'($urandom_range(0, 6));
        else if (r < 9) ld = TW'($urandom_range(0, 20000));
        else            ld = '1;
        bus.ch_load[k*TW +: TW] = ld;
      end
      cyc(1);
    end
    bus.ch_start = '0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
